// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency line memory behind a request/response handshake.
// A request is latched in IDLE, counted down in BUSY, and completed in RESP
// with a single-cycle mem_resp strobe. Protocol violations set a sticky flag.
module pmem_responder #(
    parameter int unsigned DELAY      = 10,
    parameter int unsigned INDEX_BITS = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    input  logic         mem_read,
    input  logic         mem_write,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic         busy,
    output logic         proto_err
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam logic [7:0]  LOAD  = 8'(DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]            count;
    logic [15:4]           addr_q;
    logic [127:0]          wdata_q;
    logic                  read_q;
    logic                  write_q;
    logic [INDEX_BITS-1:0] index_q;

    // Storage powers up zero and is deliberately outside the reset domain.
    logic [127:0] mem [LINES] = '{default: '0};

    logic req_any;
    logic accept;
    logic abort;
    logic mismatch;
    logic finish;
    logic commit_write;
    logic load_read;
    logic proto_set;

    // Offset bits within a line carry no meaning for this memory.
    logic unused_offset;
    assign unused_offset = &{1'b0, mem_address[3:0]};

    assign index_q = addr_q[INDEX_BITS+3:4];
    assign req_any = mem_read | mem_write;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; abort takes priority over completion in BUSY.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_any) state_next = BUSY;
            BUSY: begin
                if (!req_any)           state_next = IDLE;
                else if (count == 8'd0) state_next = RESP;
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and control decode from the current state and live request.
    always_comb begin
        busy         = (state != IDLE);
        accept       = (state == IDLE) && req_any;
        abort        = (state == BUSY) && !req_any;
        mismatch     = (state == BUSY) && req_any &&
                       ((mem_address[15:4] != addr_q) ||
                        (mem_read != read_q) || (mem_write != write_q));
        finish       = (state == BUSY) && req_any && (count == 8'd0);
        commit_write = finish && write_q;
        load_read    = finish && !write_q;
        proto_set    = (accept && mem_read && mem_write) || abort || mismatch;
    end

    // Request latch, countdown, response strobe, read data and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
        end else begin
            if (accept) begin
                count   <= LOAD;
                addr_q  <= mem_address[15:4];
                wdata_q <= mem_wdata;
                read_q  <= mem_read;
                write_q <= mem_write;
            end else if ((state == BUSY) && (count != 8'd0)) begin
                count <= count - 8'd1;
            end
            mem_resp <= finish;
            if (load_read) mem_rdata <= mem[index_q];
            if (proto_set) proto_err <= 1'b1;
        end
    end

    // Line write commits only on the completion edge, never on abort or reset.
    always_ff @(posedge clk) begin
        if (commit_write) mem[index_q] <= wdata_q;
    end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 The module SHALL have parameter DELAY, default 10: cycles from request acceptance to mem_resp; legal range 1..255.
REQ-002 The module SHALL have parameter INDEX_BITS, default 12: log2 of the number of 128-bit storage lines; legal range 1..12.
REQ-003 The module SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-005 The module SHALL have port mem_address, input, width 16: byte address from the L2 cache.
REQ-006 The module SHALL have port mem_wdata, input, width 128: line write data.
REQ-007 The module SHALL have port mem_read, input, width 1: read request, held high until mem_resp.
REQ-008 The module SHALL have port mem_write, input, width 1: write request, held high until mem_resp.
REQ-009 The module SHALL have port mem_rdata, output, width 128: registered line read data.
REQ-010 The module SHALL have port mem_resp, output, width 1: registered completion strobe, exactly one cycle wide.
REQ-011 The module SHALL have port busy, output, width 1: high while a transaction is in flight.
REQ-012 The module SHALL have port proto_err, output, width 1: sticky protocol-violation flag.

Function
REQ-013 Storage SHALL be 2^INDEX_BITS lines of 128 bits, indexed by mem_address[INDEX_BITS+3:4].
- mem_address[3:0] ignored.
- Bits above INDEX_BITS+3 ignored, so higher addresses alias.
REQ-014 The controller SHALL use the states IDLE, BUSY and RESP.
REQ-015 In IDLE, on a clock edge with mem_read or mem_write high, the controller SHALL:
- latch the address, wdata and operation;
- load the counter with DELAY-1;
- enter BUSY.
REQ-016 If mem_read and mem_write are both high at acceptance, the controller SHALL perform a write and set proto_err.
REQ-017 In BUSY, the counter SHALL decrement each cycle; the controller SHALL enter RESP on the edge where the counter equals 0.
- For DELAY=1, BUSY lasts one cycle.
REQ-018 Latency SHALL be exact: with acceptance at edge 0, mem_resp SHALL be high during the cycle following edge DELAY, for exactly one cycle.
REQ-019 On entry to RESP, a read SHALL load mem_rdata with the latched line, and a write SHALL commit the latched wdata to the latched line.
- A write SHALL leave mem_rdata unchanged.
REQ-020 RESP SHALL return to IDLE unconditionally after one cycle.
- A request still high in IDLE SHALL be accepted as a new transaction on the next edge.
- Back-to-back transactions therefore have a one-cycle gap.
REQ-021 mem_rdata SHALL hold its last value outside RESP.
REQ-022 busy SHALL be high in BUSY and RESP, and low in IDLE.
REQ-023 In BUSY, if mem_address[15:4] differs from the latched value, or the operation changes, the controller SHALL set proto_err and complete using the latched values.
REQ-024 In BUSY, if mem_read and mem_write are both low, the controller SHALL:
- abort to IDLE on that edge;
- assert no mem_resp;
- commit no write;
- set proto_err.
REQ-025 proto_err SHALL clear only on reset.
REQ-026 Storage SHALL power up all zero and SHALL NOT be affected by reset.

Reset
REQ-027 While rst_n is low, the module SHALL immediately hold:
- state = IDLE, counter = 0;
- mem_resp = 0, busy = 0, proto_err = 0;
- mem_rdata = 0.
REQ-028 If rst_n asserts during BUSY, the in-flight write SHALL NOT commit and no mem_resp SHALL be issued.
REQ-029 After rst_n deasserts, the first edge with a request high SHALL be the acceptance edge.

Verification
REQ-030 The bench SHALL cover these directed scenarios with DELAY=10:
- Reset, then read 0x0040 -> mem_resp exactly one cycle after edge 10; mem_rdata = 0; busy high for cycles 1-11.
- Write 0x0120 with 0x0123456789ABCDEF_FEDCBA9876543210, then read 0x012F -> same data; offset ignored.
- mem_read and mem_write both high at address 0x0200 with data 0xA5 repeated -> write commits; proto_err = 1; a later read of 0x0200 returns 0xA5 repeated.
- Address changes 0x0300 -> 0x0310 in cycle 4 of a read -> proto_err = 1; the response carries line 0x0300 data at the normal time.
- rst_n low in cycle 5 of a write to 0x0400 -> mem_resp stays 0; a later read of 0x0400 returns the old contents.
- mem_read dropped in cycle 3 -> no mem_resp; proto_err = 1; a new request afterwards completes with DELAY latency.
REQ-031 The bench SHALL repeat the scenarios with DELAY=1 (mem_resp one cycle after edge 1).
REQ-032 The bench SHALL repeat the scenarios with INDEX_BITS=4 and check that address 0x0100 aliases 0x0000.
